vga_rect_painter: RTL and testbench

- Pixel colour generator between the VGA sync/timing module and the RGB565 DAC pins.
- Draws up to N_RECT runtime-configurable, solid-colour rectangles over a configurable background colour.
- Supports per-rectangle enable and blink; lower index has higher priority where rectangles overlap.
- Configuration is double-buffered: writes go to staging registers and are copied to active registers only on a frame tick, so no tearing occurs mid-frame.

---
 rtl/vga_rect_painter_if.sv | 31 +++
 rtl/vga_rect_painter.sv | 107 ++++++++++
 tb/tb_vga_rect_painter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_painter_if.sv
// Pixel-side bus between the VGA timing source, the configuration writer and the rectangle painter.
// The master drives timing and configuration; the slave returns RGB.
interface vga_rect_painter_if #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
);
    logic           Ready_Sig;
    logic [10:0]    Column_Addr_Sig;
    logic [9:0]     Row_Addr_Sig;
    logic           Frame_Tick;
    logic           Cfg_We;
    logic [2:0]     Cfg_Idx;
    logic [2:0]     Cfg_Field;
    logic [15:0]    Cfg_Data;
    logic [R_W-1:0] Red_Sig;
    logic [G_W-1:0] Green_Sig;
    logic [B_W-1:0] Blue_Sig;

    modport master (
        output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Frame_Tick,
        output Cfg_We, Cfg_Idx, Cfg_Field, Cfg_Data,
        input  Red_Sig, Green_Sig, Blue_Sig
    );

    modport slave (
        input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Frame_Tick,
        input  Cfg_We, Cfg_Idx, Cfg_Field, Cfg_Data,
        output Red_Sig, Green_Sig, Blue_Sig
    );
endinterface

// File: rtl/vga_rect_painter.sv
// Paints up to N_RECT solid rectangles over a background colour.
// Configuration is staged and swapped into the active set on each Frame_Tick.
module vga_rect_painter #(
    parameter int N_RECT       = 4,
    parameter int R_W          = 5,
    parameter int G_W          = 6,
    parameter int B_W          = 5,
    parameter int BLINK_FRAMES = 30
) (
    input logic              CLK,
    input logic              RST_n,
    vga_rect_painter_if.slave bus
);
    localparam int C_W = R_W + G_W + B_W;
    localparam int CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [10:0]    x0;
        logic [9:0]     y0;
        logic [10:0]    x1;
        logic [9:0]     y1;
        logic [C_W-1:0] col;
        logic           en;
        logic           blk;
    } rect_t;

    rect_t [N_RECT-1:0] stg_q, act_q;
    logic [C_W-1:0]     bg_stg_q, bg_act_q;
    logic [CW-1:0]      blk_cnt_q;
    logic               phase_q;
    logic [N_RECT-1:0]  vis;
    logic [C_W-1:0]     col_d, col_q;
    logic               rdy_q;

    // Staging registers: the index compare filters out-of-range rectangles implicitly.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stg_q    <= '0;
            bg_stg_q <= '0;
        end else if (bus.Cfg_We) begin
            for (int i = 0; i < N_RECT; i++) begin
                if (bus.Cfg_Idx == 3'(i)) begin
                    case (bus.Cfg_Field)
                        3'd0: stg_q[i].x0  <= bus.Cfg_Data[10:0];
                        3'd1: stg_q[i].y0  <= bus.Cfg_Data[9:0];
                        3'd2: stg_q[i].x1  <= bus.Cfg_Data[10:0];
                        3'd3: stg_q[i].y1  <= bus.Cfg_Data[9:0];
                        3'd4: stg_q[i].col <= bus.Cfg_Data[C_W-1:0];
                        3'd5: begin
                            stg_q[i].en  <= bus.Cfg_Data[0];
                            stg_q[i].blk <= bus.Cfg_Data[1];
                        end
                        default: ;
                    endcase
                end
            end
            if ({1'b0, bus.Cfg_Idx} == 4'(N_RECT) && bus.Cfg_Field == 3'd4)
                bg_stg_q <= bus.Cfg_Data[C_W-1:0];
        end
    end

    // Frame swap and blink phase; the copy sees staging values from before any same-cycle write.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            act_q     <= '0;
            bg_act_q  <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (bus.Frame_Tick) begin
            act_q    <= stg_q;
            bg_act_q <= bg_stg_q;
            if (blk_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                blk_cnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_RECT; g++) begin : g_rect
        assign vis[g] = (bus.Column_Addr_Sig >= act_q[g].x0) && (bus.Column_Addr_Sig < act_q[g].x1) &&
                        (bus.Row_Addr_Sig >= act_q[g].y0) && (bus.Row_Addr_Sig < act_q[g].y1) &&
                        act_q[g].en && !(act_q[g].blk && phase_q);
    end

    // Walk from highest index down so the lowest visible index wins.
    always_comb begin
        col_d = bg_act_q;
        for (int i = N_RECT - 1; i >= 0; i--)
            if (vis[i]) col_d = act_q[i].col;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rdy_q <= 1'b0;
            col_q <= '0;
        end else begin
            rdy_q <= bus.Ready_Sig;
            col_q <= col_d;
        end
    end

    assign bus.Red_Sig   = rdy_q ? col_q[C_W-1 -: R_W]       : '0;
    assign bus.Green_Sig = rdy_q ? col_q[G_W+B_W-1 -: G_W]   : '0;
    assign bus.Blue_Sig  = rdy_q ? col_q[B_W-1:0]            : '0;
endmodule

// File: tb/tb_vga_rect_painter.sv
// Bench for vga_rect_painter: directed scenarios plus random traffic against a frame-level reference model.
module tb_vga_rect_painter;
    localparam int N_RECT = 4;
    localparam int BLINK  = 2;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    vga_rect_painter_if #(.R_W(5), .G_W(6), .B_W(5)) bus();

    vga_rect_painter #(
        .N_RECT(N_RECT), .R_W(5), .G_W(6), .B_W(5), .BLINK_FRAMES(BLINK)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .bus(bus)
    );

    logic [15:0] rgb;
    assign rgb = {bus.Red_Sig, bus.Green_Sig, bus.Blue_Sig};

    // Reference model: fields 0..5 per rectangle, background colour at [N_RECT][4].
    int m_stg [N_RECT+1][6];
    int m_act [N_RECT+1][6];
    int ticks;
    int vecs, errs;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i <= N_RECT; i++)
            for (int f = 0; f < 6; f++) begin
                m_stg[i][f] = 0;
                m_act[i][f] = 0;
            end
        ticks = 0;
    endfunction

    function automatic void m_write(input int idx, input int f, input int d);
        if (idx > N_RECT || f > 5 || (idx == N_RECT && f != 4)) return;
        case (f)
            0, 2:    m_stg[idx][f] = d & 'h7FF;
            1, 3:    m_stg[idx][f] = d & 'h3FF;
            4:       m_stg[idx][f] = d & 'hFFFF;
            default: m_stg[idx][f] = d & 3;
        endcase
    endfunction

    function automatic logic [15:0] ref_pix(input bit rdy, input int c, input int r);
        bit hidden;
        if (!rdy) return 16'h0;
        hidden = ((ticks / BLINK) % 2) == 1;
        for (int i = 0; i < N_RECT; i++) begin
            if ((m_act[i][5] & 1) != 0 && !((m_act[i][5] & 2) != 0 && hidden) &&
                c >= m_act[i][0] && c < m_act[i][2] && r >= m_act[i][1] && r < m_act[i][3])
                return 16'(m_act[i][4]);
        end
        return 16'(m_act[N_RECT][4]);
    endfunction

    // One pixel clock: drive, predict from pre-edge state, advance model, check after the edge.
    task automatic step(input bit rdy, input int c, input int r, input bit we,
                        input int idx, input int f, input int d, input bit tick);
        logic [15:0] exp;
        bus.Ready_Sig       = rdy;
        bus.Column_Addr_Sig = 11'(c);
        bus.Row_Addr_Sig    = 10'(r);
        bus.Cfg_We          = we;
        bus.Cfg_Idx         = 3'(idx);
        bus.Cfg_Field       = 3'(f);
        bus.Cfg_Data        = 16'(d);
        bus.Frame_Tick      = tick;
        exp = RST_n ? ref_pix(rdy, c, r) : 16'h0;
        @(posedge CLK);
        if (RST_n) begin
            if (tick) begin
                m_act = m_stg;
                ticks++;
            end
            if (we) m_write(idx, f, d);
        end
        #1;
        chk("pix", rgb, exp);
    endtask

    task automatic px(input int c, input int r, input string tag, input logic [15:0] want);
        step(1'b1, c, r, 1'b0, 0, 0, 0, 1'b0);
        chk(tag, rgb, want);
    endtask

    task automatic cfg(input int idx, input int f, input int d);
        step(1'b0, 0, 0, 1'b1, idx, f, d, 1'b0);
    endtask

    task automatic tick();
        step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic rect(input int idx, input int x0, input int y0, input int x1, input int y1,
                        input int col, input int ctrl);
        cfg(idx, 0, x0); cfg(idx, 1, y0); cfg(idx, 2, x1); cfg(idx, 3, y1);
        cfg(idx, 4, col); cfg(idx, 5, ctrl);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        m_reset();
        RST_n = 1'b0;
        #2;

        // Held in reset with scanning addresses and stray writes: outputs stay black.
        for (int k = 0; k < 2000; k++)
            step(1'b1, k % 800, (k / 800) * 37, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 65535),
                 $urandom_range(0, 9) == 0);

        RST_n = 1'b1;
        #1;
        chk("rel_mid_line", rgb, 16'h0);
        px(400, 300, "first_pix", 16'h0);

        rect(0, 0, 0, 100, 100, 16'hF800, 1);
        px(99, 99, "pre_tick", 16'h0);
        tick();
        px(99, 99, "red_99_99", 16'hF800);
        px(100, 99, "edge_x", 16'h0);
        px(99, 100, "edge_y", 16'h0);

        rect(0, 10, 10, 50, 50, 16'h07E0, 1);
        rect(1, 30, 30, 80, 80, 16'h001F, 1);
        cfg(N_RECT, 4, 16'hFFFF);
        tick();
        px(40, 40, "ovl_green", 16'h07E0);
        px(60, 60, "ovl_blue", 16'h001F);
        px(5, 5, "ovl_bg", 16'hFFFF);

        rect(0, 0, 0, 100, 100, 16'hF800, 1);
        tick();
        step(1'b0, 0, 0, 1'b1, 0, 2, 200, 1'b1);
        px(150, 50, "same_cyc_old", 16'hFFFF);
        tick();
        px(150, 50, "same_cyc_new", 16'hF800);

        cfg(0, 0, 50);
        cfg(0, 2, 50);
        tick();
        px(50, 5, "degenerate", 16'hFFFF);

        cfg(7, 4, 16'h1234);
        cfg(7, 0, 0);
        cfg(N_RECT, 0, 5);
        cfg(1, 6, 0);
        cfg(1, 7, 0);
        tick();
        px(5, 5, "ign_bg", 16'hFFFF);
        px(60, 60, "ign_rect1", 16'h001F);

        step(1'b0, 60, 60, 1'b0, 0, 0, 0, 1'b0);
        chk("rdy0_inside", rgb, 16'h0);

        RST_n = 1'b0;
        #1;
        chk("async_rst", rgb, 16'h0);
        m_reset();
        step(1'b1, 60, 60, 1'b0, 0, 0, 0, 1'b0);
        RST_n = 1'b1;

        // Blink: rectangle shown while (ticks/2) is even, background otherwise.
        rect(0, 0, 0, 100, 100, 16'hF800, 3);
        cfg(N_RECT, 4, 16'h0841);
        for (int t = 1; t <= 6; t++) begin
            tick();
            px(10, 10, "blink", ((t / 2) % 2 == 0) ? 16'hF800 : 16'h0841);
        end

        for (int k = 0; k < 4000; k++) begin
            int f;
            int d;
            f = $urandom_range(0, 7);
            d = (f == 4) ? int'($urandom_range(0, 65535)) :
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7), f, d,
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
